// File: rtl/vram_scheduler.sv
// Single-port VRAM arbiter: display fetch owns every 4th active pixel slot,
// the host takes any other cycle through a req/ack handshake.
module vram_scheduler #(
    parameter int HACTIVE    = 640,
    parameter int VACTIVE    = 480,
    parameter int HACT_START = 0,
    parameter int VACT_START = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  HCNT,
    input  logic [9:0]  VCNT,
    input  logic        HREQ,
    input  logic        HWE,
    input  logic [16:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic        HACK,
    output logic [31:0] HRDATA,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic [16:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    output logic [7:0]  PIX_OUT,
    output logic        PIX_VALID
);

    localparam logic [0:0]  S_IDLE     = 1'b0;
    localparam logic [0:0]  S_DONE     = 1'b1;
    localparam logic [16:0] LINE_WORDS = 17'(HACTIVE / 4);

    // Offsets wrap below the start values, landing outside the active range.
    logic [9:0] x, y;
    logic       active, disp_slot, frame_clr, line_end, host_issue;

    assign x         = HCNT - 10'(HACT_START);
    assign y         = VCNT - 10'(VACT_START);
    assign active    = (x < 10'(HACTIVE)) && (y < 10'(VACTIVE));
    assign disp_slot = active && (x[1:0] == 2'b00);
    assign frame_clr = (HCNT == 10'd0) && (VCNT == 10'(VACT_START));
    assign line_end  = active && (x == 10'(HACTIVE - 1));

    logic [16:0] linebase_q, linebase_d, base_eff;

    // Bypass the clear so a first-pixel slot on the clear cycle already fetches word 0.
    assign base_eff   = frame_clr ? 17'd0 : linebase_q;
    assign linebase_d = base_eff + (line_end ? LINE_WORDS : 17'd0);

    logic [0:0] state_q, state_d;
    logic       we_q, we_d;

    assign host_issue = (state_q == S_IDLE) && HREQ && !disp_slot;
    assign state_d    = host_issue ? S_DONE : S_IDLE;
    assign we_d       = host_issue ? HWE : we_q;

    logic        en_d, mwe_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    always_comb begin
        en_d    = 1'b0;
        mwe_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (disp_slot) begin
            en_d   = 1'b1;
            addr_d = base_eff + {9'd0, x[9:2]};
        end else if (host_issue) begin
            en_d    = 1'b1;
            mwe_d   = HWE;
            addr_d  = HADDR;
            wdata_d = HWDATA;
        end
        if (RST) begin
            en_d    = 1'b0;
            mwe_d   = 1'b0;
            addr_d  = 17'd0;
            wdata_d = 32'd0;
        end
    end

    assign MEM_EN    = en_d;
    assign MEM_WE    = mwe_d;
    assign MEM_ADDR  = addr_d;
    assign MEM_WDATA = wdata_d;
    assign HACK      = (state_q == S_DONE);
    assign HRDATA    = ((state_q == S_DONE) && !we_q) ? MEM_RDATA : 32'd0;

    // Fetch at t, RAM data at t+1, word buffer at t+2, shifter at t+3, pixel reg at t+4.
    logic [2:0]  act_q;
    logic [1:0]  slot_q;
    logic [31:0] word_q, shift_q;
    logic [7:0]  pix_q;
    logic        pix_vld_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            linebase_q <= 17'd0;
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= 17'd0;
            wdata_q    <= 32'd0;
            act_q      <= 3'd0;
            slot_q     <= 2'd0;
            word_q     <= 32'd0;
            shift_q    <= 32'd0;
            pix_q      <= 8'd0;
            pix_vld_q  <= 1'b0;
        end else begin
            linebase_q <= linebase_d;
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            act_q      <= {act_q[1:0], active};
            slot_q     <= {slot_q[0], disp_slot};
            if (slot_q[0]) word_q <= MEM_RDATA;
            shift_q    <= slot_q[1] ? word_q : {8'd0, shift_q[31:8]};
            pix_q      <= act_q[2] ? shift_q[7:0] : 8'd0;
            pix_vld_q  <= act_q[2];
        end
    end

    assign PIX_OUT   = pix_q;
    assign PIX_VALID = pix_vld_q;

endmodule

// File: tb/tb_vram_scheduler.sv
// Bench for vram_scheduler: drives HCNT/VCNT directly, models the RAM and
// scoreboards pixel stream and host acknowledgements.
module tb_vram_scheduler;

    localparam int HA = 640;
    localparam int VA = 480;

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  HCNT, VCNT;
    logic        HREQ, HWE;
    logic [16:0] HADDR;
    logic [31:0] HWDATA;
    logic        HACK;
    logic [31:0] HRDATA;
    logic        MEM_EN, MEM_WE;
    logic [16:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic [7:0]  PIX_OUT;
    logic        PIX_VALID;

    vram_scheduler dut (
        .CLK(CLK), .RST(RST), .HCNT(HCNT), .VCNT(VCNT),
        .HREQ(HREQ), .HWE(HWE), .HADDR(HADDR), .HWDATA(HWDATA),
        .HACK(HACK), .HRDATA(HRDATA),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .PIX_OUT(PIX_OUT), .PIX_VALID(PIX_VALID)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    function automatic logic [31:0] pat(input logic [16:0] a);
        if (a == 17'd162) return 32'h44332211;
        return ({15'd0, a} * 32'h9E3779B1) ^ 32'h12345678;
    endfunction

    // RAM model: background pattern, overlaid by whatever gets written.
    logic [31:0] wr_mem [int];
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) wr_mem[int'(MEM_ADDR)] = MEM_WDATA;
            else MEM_RDATA <= wr_mem.exists(int'(MEM_ADDR)) ? wr_mem[int'(MEM_ADDR)] : pat(MEM_ADDR);
        end
    end

    typedef struct packed { logic chk; logic vld; logic [7:0] pix; } pix_t;
    typedef struct packed { logic rd; logic [31:0] data; } host_t;

    pix_t  pix_sb[$];
    host_t host_sb[$];
    pix_t  pexp;
    bit    pexp_ok;
    logic [31:0] mword;
    bit    mok;
    int    prev_h, prev_v;

    task automatic model_reset();
        pix_t z;
        z = '{chk: 1'b1, vld: 1'b0, pix: 8'd0};
        pix_sb.delete();
        repeat (4) pix_sb.push_back(z);
        mok = 0; prev_h = -2; prev_v = -2; mword = 32'd0;
    endtask

    // Expected pixel for this cycle's counters; checkable only when the
    // word fetch feeding it was part of a contiguous run.
    task automatic model_step(input int h, input int v);
        bit act;
        pix_t e;
        act = (h < HA) && (v < VA);
        if (act && (h % 4 == 0)) begin
            mword = pat(17'(v * (HA / 4) + h / 4));
            mok = 1;
        end else if (act) begin
            mok = mok && (prev_h == h - 1) && (prev_v == v);
        end
        e.chk = !act || mok;
        e.vld = act;
        e.pix = act ? mword[8 * (h % 4) +: 8] : 8'd0;
        prev_h = h; prev_v = v;
        pix_sb.push_back(e);
        pexp_ok = 0;
        if (pix_sb.size() > 4) begin
            pexp = pix_sb.pop_front();
            pexp_ok = pexp.chk;
        end
    endtask

    task automatic drive(input int h, input int v, input logic req, input logic we,
                         input logic [16:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        HCNT = 10'(h); VCNT = 10'(v); HREQ = req; HWE = we; HADDR = a; HWDATA = d;
        model_step(h, v);
        #1;
    endtask

    task automatic test_reset();
        logic [92:0] outs;
        host_t hx;
        repeat (3) @(posedge CLK);
        #2;
        outs = {HACK, HRDATA, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, PIX_OUT, PIX_VALID};
        n_total++;
        if (outs !== '0) $display("FAIL reset_outs: got %h exp 0", outs); else n_pass++;

        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        model_step(0, 0);
        for (int x = 1; x <= 4; x++) drive(x, 0, 1'b0, 1'b0, 17'd0, 32'd0);
        drive(5, 0, 1'b1, 1'b0, 17'h55, 32'd0);
        n_total++;
        if (MEM_EN !== 1'b1 || MEM_ADDR !== 17'h55 || PIX_VALID !== 1'b1)
            $display("FAIL pre_reset_issue: got en=%b addr=%h pv=%b exp en=1 addr=55 pv=1", MEM_EN, MEM_ADDR, PIX_VALID);
        else n_pass++;

        #1 RST = 1'b1;
        #1;
        outs = {HACK, HRDATA, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, PIX_OUT, PIX_VALID};
        n_total++;
        if (outs !== '0) $display("FAIL reset_async: got %h exp 0", outs); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #2;
            n_total++;
            if (HACK !== 1'b0) $display("FAIL reset_no_ack%0d: got %b exp 0", i, HACK); else n_pass++;
        end

        @(posedge CLK); #1;
        RST = 1'b0; HCNT = 10'd700; VCNT = 10'd0;
        model_reset();
        model_step(700, 0);
        host_sb.push_back('{rd: 1'b1, data: pat(17'h55)});
        #1;
        n_total++;
        if (HACK !== 1'b0 || MEM_EN !== 1'b1 || MEM_ADDR !== 17'h55)
            $display("FAIL release_issue: got ack=%b en=%b addr=%h exp ack=0 en=1 addr=55", HACK, MEM_EN, MEM_ADDR);
        else n_pass++;
        drive(701, 0, 1'b1, 1'b0, 17'h55, 32'd0);
        n_total++;
        if (HACK !== 1'b1) $display("FAIL release_ack: got %b exp 1", HACK);
        else begin
            hx = host_sb.pop_front();
            if (HRDATA !== hx.data) $display("FAIL release_rdata: got %h exp %h", HRDATA, hx.data);
            else n_pass++;
        end
        drive(702, 0, 1'b0, 1'b0, 17'd0, 32'd0);
        n_total++;
        if (HACK !== 1'b0) $display("FAIL release_ack_pulse: got %b exp 0", HACK); else n_pass++;
    endtask

    task automatic test_display_fetch();
        logic [31:0] w;
        w = 32'h44332211;
        drive(639, 0, 1'b0, 1'b0, 17'd0, 32'd0);
        for (int x = 0; x < 16; x++) begin
            drive(x, 1, 1'b0, 1'b0, 17'd0, 32'd0);
            if (pexp_ok) begin
                n_total++;
                if (PIX_OUT !== pexp.pix || PIX_VALID !== pexp.vld)
                    $display("FAIL fetch_pix_x%0d: got %h/%b exp %h/%b", x, PIX_OUT, PIX_VALID, pexp.pix, pexp.vld);
                else n_pass++;
            end
            if (x == 8) begin
                n_total++;
                if (MEM_EN !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 17'd162)
                    $display("FAIL fetch_addr: got en=%b we=%b addr=%0d exp en=1 we=0 addr=162", MEM_EN, MEM_WE, MEM_ADDR);
                else n_pass++;
            end
            if (x >= 12) begin
                n_total++;
                if (PIX_OUT !== w[8 * (x - 12) +: 8] || PIX_VALID !== 1'b1)
                    $display("FAIL fetch_byte%0d: got %h/%b exp %h/1", x - 12, PIX_OUT, PIX_VALID, w[8 * (x - 12) +: 8]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blank_output();
        for (int x = 636; x < 648; x++) begin
            drive(x, 1, 1'b0, 1'b0, 17'd0, 32'd0);
            if (pexp_ok) begin
                n_total++;
                if (PIX_OUT !== pexp.pix || PIX_VALID !== pexp.vld)
                    $display("FAIL blank_pix_x%0d: got %h/%b exp %h/%b", x, PIX_OUT, PIX_VALID, pexp.pix, pexp.vld);
                else n_pass++;
            end
            if (x == 636) begin
                n_total++;
                if (MEM_EN !== 1'b1 || MEM_ADDR !== 17'd319)
                    $display("FAIL last_slot_addr: got en=%b addr=%0d exp en=1 addr=319", MEM_EN, MEM_ADDR);
                else n_pass++;
            end
            if (x >= 640 && x <= 643) begin
                n_total++;
                if (MEM_EN !== 1'b0) $display("FAIL blank_no_fetch_x%0d: got %b exp 0", x, MEM_EN); else n_pass++;
            end
            if (x >= 644) begin
                n_total++;
                if (PIX_OUT !== 8'd0 || PIX_VALID !== 1'b0)
                    $display("FAIL blank_pix_zero_x%0d: got %h/%b exp 00/0", x, PIX_OUT, PIX_VALID);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blank_write();
        host_sb.push_back('{rd: 1'b0, data: 32'd0});
        drive(700, 1, 1'b1, 1'b1, 17'h123, 32'hDEADBEEF);
        n_total++;
        if (MEM_EN !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== 17'h123 || MEM_WDATA !== 32'hDEADBEEF || HACK !== 1'b0)
            $display("FAIL wr_issue: got en=%b we=%b addr=%h data=%h ack=%b exp 1 1 123 deadbeef 0",
                     MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, HACK);
        else n_pass++;
        drive(701, 1, 1'b1, 1'b1, 17'h124, 32'hCAFEF00D);
        n_total++;
        if (HACK !== 1'b1 || MEM_EN !== 1'b0)
            $display("FAIL wr_ack_no_regrant: got ack=%b en=%b exp ack=1 en=0", HACK, MEM_EN);
        else begin n_pass++; void'(host_sb.pop_front()); end
        host_sb.push_back('{rd: 1'b0, data: 32'd0});
        drive(702, 1, 1'b1, 1'b1, 17'h124, 32'hCAFEF00D);
        n_total++;
        if (MEM_EN !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== 17'h124 || MEM_WDATA !== 32'hCAFEF00D)
            $display("FAIL wr_regrant: got en=%b we=%b addr=%h data=%h exp 1 1 124 cafef00d", MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA);
        else n_pass++;
        drive(703, 1, 1'b0, 1'b0, 17'd0, 32'd0);
        n_total++;
        if (HACK !== 1'b1) $display("FAIL wr_ack2: got %b exp 1", HACK);
        else begin n_pass++; void'(host_sb.pop_front()); end
        drive(704, 1, 1'b0, 1'b0, 17'd0, 32'd0);
        n_total++;
        if (MEM_EN !== 1'b0 || MEM_WE !== 1'b0 || MEM_ADDR !== 17'h124 || MEM_WDATA !== 32'hCAFEF00D || HACK !== 1'b0)
            $display("FAIL idle_hold: got en=%b we=%b addr=%h data=%h ack=%b exp 0 0 124 cafef00d 0",
                     MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, HACK);
        else n_pass++;
    endtask

    task automatic test_collision();
        host_t hx;
        for (int x = 0; x < 12; x++) begin
            if (x == 4) host_sb.push_back('{rd: 1'b1, data: 32'hDEADBEEF});
            drive(x, 2, (x >= 4 && x <= 6), 1'b0, 17'h123, 32'd0);
            if (pexp_ok) begin
                n_total++;
                if (PIX_OUT !== pexp.pix || PIX_VALID !== pexp.vld)
                    $display("FAIL col_pix_x%0d: got %h/%b exp %h/%b", x, PIX_OUT, PIX_VALID, pexp.pix, pexp.vld);
                else n_pass++;
            end
            if (x == 4 || x == 8) begin
                n_total++;
                if (MEM_EN !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 17'(320 + x / 4))
                    $display("FAIL col_disp_x%0d: got en=%b we=%b addr=%0d exp 1 0 %0d", x, MEM_EN, MEM_WE, MEM_ADDR, 320 + x / 4);
                else n_pass++;
            end
            if (x == 5) begin
                n_total++;
                if (MEM_EN !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 17'h123 || HACK !== 1'b0)
                    $display("FAIL col_host_issue: got en=%b we=%b addr=%h ack=%b exp 1 0 123 0", MEM_EN, MEM_WE, MEM_ADDR, HACK);
                else n_pass++;
            end
            if (x == 6) begin
                n_total++;
                if (HACK !== 1'b1 || MEM_EN !== 1'b0) $display("FAIL col_ack: got ack=%b en=%b exp ack=1 en=0", HACK, MEM_EN);
                else begin
                    hx = host_sb.pop_front();
                    if (HRDATA !== hx.data) $display("FAIL col_rdata: got %h exp %h", HRDATA, hx.data);
                    else n_pass++;
                end
            end
            if (x == 7) begin
                n_total++;
                if (HACK !== 1'b0 || MEM_EN !== 1'b0) $display("FAIL col_after: got ack=%b en=%b exp 0 0", HACK, MEM_EN);
                else n_pass++;
            end
        end
    endtask

    task automatic test_frame_wrap();
        drive(0, 0, 1'b0, 1'b0, 17'd0, 32'd0);
        n_total++;
        if (MEM_EN !== 1'b1 || MEM_ADDR !== 17'd0) $display("FAIL clr_addr: got en=%b addr=%0d exp 1 0", MEM_EN, MEM_ADDR);
        else n_pass++;
        for (int y = 0; y < VA - 1; y++) drive(639, y, 1'b0, 1'b0, 17'd0, 32'd0);
        for (int x = 632; x < 644; x++) begin
            drive(x, VA - 1, 1'b0, 1'b0, 17'd0, 32'd0);
            if (pexp_ok) begin
                n_total++;
                if (PIX_OUT !== pexp.pix || PIX_VALID !== pexp.vld)
                    $display("FAIL wrap_pix_x%0d: got %h/%b exp %h/%b", x, PIX_OUT, PIX_VALID, pexp.pix, pexp.vld);
                else n_pass++;
            end
            if (x == 636) begin
                n_total++;
                if (MEM_EN !== 1'b1 || MEM_ADDR !== 17'd76799)
                    $display("FAIL wrap_last_addr: got en=%b addr=%0d exp 1 76799", MEM_EN, MEM_ADDR);
                else n_pass++;
            end
        end
        drive(0, VA, 1'b0, 1'b0, 17'd0, 32'd0);
        n_total++;
        if (MEM_EN !== 1'b0) $display("FAIL vblank_no_fetch: got %b exp 0", MEM_EN); else n_pass++;
        for (int x = 0; x < 8; x++) begin
            drive(x, 0, 1'b0, 1'b0, 17'd0, 32'd0);
            if (x == 0 || x == 4) begin
                n_total++;
                if (MEM_EN !== 1'b1 || MEM_ADDR !== 17'(x / 4))
                    $display("FAIL wrap_first_addr_x%0d: got en=%b addr=%0d exp 1 %0d", x, MEM_EN, MEM_ADDR, x / 4);
                else n_pass++;
            end
        end
        for (int x = 8; x < 12; x++) begin
            drive(x, 0, 1'b0, 1'b0, 17'd0, 32'd0);
            if (pexp_ok) begin
                n_total++;
                if (PIX_OUT !== pexp.pix || PIX_VALID !== pexp.vld)
                    $display("FAIL wrap_new_pix_x%0d: got %h/%b exp %h/%b", x, PIX_OUT, PIX_VALID, pexp.pix, pexp.vld);
                else n_pass++;
            end
        end
    endtask

    initial begin
        RST = 1'b1; HCNT = 10'd0; VCNT = 10'd0;
        HREQ = 1'b0; HWE = 1'b0; HADDR = 17'd0; HWDATA = 32'd0;
        model_reset();
        test_reset();
        test_display_fetch();
        test_blank_output();
        test_blank_write();
        test_collision();
        test_frame_wrap();
        n_total++;
        if (host_sb.size() != 0) $display("FAIL host_ack_outstanding: got %0d pending exp 0", host_sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
